pe_stg_gen: RTL and testbench

- Parametrised next-generation systolic processing element for the INT8 output-stationary array.
- Holds a bank of preloaded signed weights, selectable per cycle, and multiplies the west operand by the selected weight.
- Accumulates the product locally in one of three modes: wrap MAC, saturating MAC, or running max.
- Drains partial sums through a south-bound shift chain, with valid qualifiers and a sticky overflow flag.

---
 rtl/pe_stg_gen.sv | 153 +++++++++++++++
 tb/tb_pe_stg_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stg_gen.sv
// Systolic INT8 processing element: selectable preloaded weight, two-stage
// multiply/accumulate (wrap, saturate, running max) and a south drain chain.
module pe_stg_gen #(
    parameter int DATA_W   = 8,
    parameter int WT_DEPTH = 4,
    parameter int ACC_W    = 32,
    parameter int TOP_W    = 48,
    parameter int IDX_W    = $clog2(WT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_sel_in,
    input  logic              wt_ld_in,
    input  logic [IDX_W-1:0]  wt_idx_in,
    input  logic [IDX_W-1:0]  wt_sel_in,
    input  logic              psu_clr_in,
    input  logic              sys_buf_en_in,
    input  logic              left_vld_in,
    input  logic [DATA_W-1:0] left_in,
    output logic              right_vld_out,
    output logic [DATA_W-1:0] right_out,
    input  logic              top_vld_in,
    input  logic [TOP_W-1:0]  top_in,
    output logic              bottom_vld_out,
    output logic [TOP_W-1:0]  bottom_out,
    output logic              ovf_out
);

    localparam int PROD_W = 2 * DATA_W;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;
    localparam logic [1:0] MODE_MAX  = 2'b11;

    logic signed [DATA_W-1:0] wt_bank_reg [WT_DEPTH];
    logic signed [DATA_W-1:0] wt_sel_val;
    logic signed [DATA_W-1:0] left_s;
    logic signed [PROD_W-1:0] mult_res;

    logic signed [PROD_W-1:0] prod_reg;
    logic                     prod_vld_reg;

    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     ovf_reg;
    logic                     ovf_next;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     sum_ovf;
    logic signed [ACC_W-1:0]  sat_val;

    logic [TOP_W-1:0]         bottom_next;
    logic                     bottom_vld_next;

    // Weight bank: a same-cycle load and read of one index yields the old value
    // because the multiply samples the registered bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WT_DEPTH; i++) begin
                wt_bank_reg[i] <= '0;
            end
        end else if (wt_ld_in) begin
            for (int i = 0; i < WT_DEPTH; i++) begin
                if (wt_idx_in == IDX_W'(i)) begin
                    wt_bank_reg[i] <= top_in[DATA_W-1:0];
                end
            end
        end
    end

    assign wt_sel_val = wt_bank_reg[wt_sel_in];
    assign left_s     = left_in;
    assign mult_res   = PROD_W'(left_s) * PROD_W'(wt_sel_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg      <= '0;
            prod_vld_reg  <= 1'b0;
            right_out     <= '0;
            right_vld_out <= 1'b0;
        end else begin
            prod_reg      <= mult_res;
            prod_vld_reg  <= left_vld_in && (mode_sel_in != MODE_PASS);
            right_out     <= left_in;
            right_vld_out <= left_vld_in;
        end
    end

    // Signed overflow: operands share a sign and the sum's sign differs.
    assign prod_ext = ACC_W'(prod_reg);
    assign sum      = acc_reg + prod_ext;
    assign sum_ovf  = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_reg[ACC_W-1]);
    assign sat_val  = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};

    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (sys_buf_en_in) begin
            acc_next = top_in[ACC_W-1:0];
        end else if (psu_clr_in) begin
            acc_next = prod_vld_reg ? prod_ext : '0;
            ovf_next = 1'b0;
        end else if (prod_vld_reg) begin
            case (mode_sel_in)
                MODE_WRAP: begin
                    acc_next = sum;
                    ovf_next = ovf_reg | sum_ovf;
                end
                MODE_SAT: begin
                    acc_next = sum_ovf ? sat_val : sum;
                    ovf_next = ovf_reg | sum_ovf;
                end
                MODE_MAX: begin
                    if (prod_ext > acc_reg) begin
                        acc_next = prod_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The drain emits the accumulator as it stood before this cycle's update.
    always_comb begin
        bottom_next     = top_in;
        bottom_vld_next = top_vld_in;
        if (sys_buf_en_in) begin
            bottom_next     = TOP_W'(acc_reg);
            bottom_vld_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg        <= '0;
            ovf_reg        <= 1'b0;
            bottom_out     <= '0;
            bottom_vld_out <= 1'b0;
        end else begin
            acc_reg        <= acc_next;
            ovf_reg        <= ovf_next;
            bottom_out     <= bottom_next;
            bottom_vld_out <= bottom_vld_next;
        end
    end

    assign ovf_out = ovf_reg;

endmodule

// File: tb/tb_pe_stg_gen.sv
// Scoreboard bench for pe_stg_gen: stimulus queues expected south-bound words,
// a negedge monitor pops and compares whenever bottom_vld_out is high.
module tb_pe_stg_gen;

    localparam int DATA_W = 8;
    localparam int WT_DEPTH = 4;
    localparam int ACC_W = 18;
    localparam int TOP_W = 48;
    localparam int IDX_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              wt_ld = 1'b0;
    logic [IDX_W-1:0]  wt_idx = '0;
    logic [IDX_W-1:0]  wt_sel = '0;
    logic              clr = 1'b0;
    logic              sb = 1'b0;
    logic              lv = 1'b0;
    logic [DATA_W-1:0] li = '0;
    logic              tv = 1'b0;
    logic [TOP_W-1:0]  ti = '0;
    logic              right_vld_out;
    logic [DATA_W-1:0] right_out;
    logic              bottom_vld_out;
    logic [TOP_W-1:0]  bottom_out;
    logic              ovf_out;

    typedef struct {
        logic [TOP_W-1:0] data;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    pe_stg_gen #(
        .DATA_W(DATA_W), .WT_DEPTH(WT_DEPTH), .ACC_W(ACC_W), .TOP_W(TOP_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode_sel_in(mode),
        .wt_ld_in(wt_ld),
        .wt_idx_in(wt_idx),
        .wt_sel_in(wt_sel),
        .psu_clr_in(clr),
        .sys_buf_en_in(sb),
        .left_vld_in(lv),
        .left_in(li),
        .right_vld_out(right_vld_out),
        .right_out(right_out),
        .top_vld_in(tv),
        .top_in(ti),
        .bottom_vld_out(bottom_vld_out),
        .bottom_out(bottom_out),
        .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [TOP_W-1:0] act, input logic [TOP_W-1:0] req);
        total++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            passed++;
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wt_ld = 1'b0;
        clr   = 1'b0;
        sb    = 1'b0;
        lv    = 1'b0;
        tv    = 1'b0;
        ti    = '0;
    endtask

    task automatic push_exp(input logic [TOP_W-1:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    // Drain the accumulator into the south chain and reload it with 'reload'.
    task automatic drain(input logic [TOP_W-1:0] reload, input logic [TOP_W-1:0] exp_d, input logic exp_o);
        sb = 1'b1;
        ti = reload;
        push_exp(exp_d, exp_o);
        tick();
    endtask

    task automatic load_wt(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] w);
        wt_ld  = 1'b1;
        wt_idx = idx;
        ti     = TOP_W'(w);
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && bottom_vld_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL bottom_unexpected: got 0x%0h, expected no valid output", bottom_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bottom_out", bottom_out, e.data);
                check("bottom_ovf", TOP_W'(ovf_out), TOP_W'(e.ovf));
            end
        end
    end

    int                      exp1 [4] = '{12, 4, 24, 52};
    int                      expm [4] = '{5, 5, 17, 17};
    logic signed [DATA_W-1:0] lm  [4] = '{8'sd1, -8'sd3, 8'sd1, 8'sd1};
    logic [IDX_W-1:0]        sm   [4] = '{2'd2, 2'd0, 2'd3, 2'd0};

    initial begin
        tick();
        tick();
        check("rst_right_out", TOP_W'(right_out), 0);
        check("rst_bottom_vld", TOP_W'(bottom_vld_out), 0);
        check("rst_ovf", TOP_W'(ovf_out), 0);
        rst_n = 1'b1;
        tick();

        load_wt(2'd0, 8'd3);
        load_wt(2'd1, 8'hFE);
        load_wt(2'd2, 8'd5);
        load_wt(2'd3, 8'd7);

        // Wrap MAC, left_in=4 across all four weights.
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            lv = 1'b1;
            li = 8'd4;
            wt_sel = IDX_W'(i);
            tick();
            check("right_out", TOP_W'(right_out), 4);
            check("right_vld", TOP_W'(right_vld_out), 1);
            if (i == 0) clr = 1'b1;
            tick();
            drain(TOP_W'(exp1[i]), TOP_W'(exp1[i]), 1'b0);
        end

        // Drain coincident with a valid product: product dropped, acc reloaded.
        lv = 1'b1;
        li = 8'd4;
        wt_sel = 2'd0;
        tick();
        drain(48'h1234, 48'd52, 1'b0);
        drain(48'hFFFF_FFFF_FFFB, 48'h1234, 1'b0);
        drain(48'd0, 48'hFFFF_FFFF_FFFB, 1'b0);

        // Sixteen products of -128*-128 = 16384 in wrap then saturating mode.
        load_wt(2'd1, 8'h80);
        for (int m = 0; m < 2; m++) begin
            mode = (m == 0) ? 2'b00 : 2'b01;
            for (int k = 0; k < 16; k++) begin
                lv = 1'b1;
                li = 8'h80;
                wt_sel = 2'd1;
                if (k == 1) clr = 1'b1;
                tick();
            end
            tick();
            check("ovf_sticky", TOP_W'(ovf_out), 1);
            drain(48'd0, (m == 0) ? 48'd0 : 48'd131071, 1'b1);
        end
        clr = 1'b1;
        tick();
        check("ovf_cleared", TOP_W'(ovf_out), 0);

        // Running max with products 5, -9, 17, 3.
        load_wt(2'd3, 8'd17);
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            lv = 1'b1;
            li = lm[i];
            wt_sel = sm[i];
            tick();
            if (i == 0) clr = 1'b1;
            tick();
            drain(TOP_W'(expm[i]), TOP_W'(expm[i]), 1'b0);
        end
        check("max_no_ovf", TOP_W'(ovf_out), 0);

        // Load and read of the same index in one cycle: multiply sees old weight 3.
        wt_ld = 1'b1;
        wt_idx = 2'd0;
        ti = 48'd100;
        lv = 1'b1;
        li = 8'd1;
        wt_sel = 2'd0;
        tick();
        tick();
        drain(48'd17, 48'd17, 1'b0);

        // Pass-through: north word forwarded, accumulator untouched.
        mode = 2'b10;
        tv = 1'b1;
        ti = 48'hABCD;
        lv = 1'b1;
        li = 8'd9;
        wt_sel = 2'd0;
        push_exp(48'hABCD, 1'b0);
        tick();
        tick();
        drain(48'd100, 48'd17, 1'b0);

        // Asynchronous reset with acc=100 and a product in flight.
        mode = 2'b00;
        lv = 1'b1;
        li = 8'd5;
        wt_sel = 2'd0;
        tick();
        check("pre_rst_right_out", TOP_W'(right_out), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_right_out", TOP_W'(right_out), 0);
        check("async_rst_right_vld", TOP_W'(right_vld_out), 0);
        check("async_rst_bottom", bottom_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        lv = 1'b1;
        li = 8'd2;
        wt_sel = 2'd0;
        tick();
        tick();
        drain(48'd0, 48'd0, 1'b0);

        repeat (3) tick();
        check("queue_empty", TOP_W'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
